// File: rtl/alu_sequencer.sv
// alu_sequencer: program-counter driven instruction walker with a two-stage
// fetch/execute pipeline. Instructions are written into a local memory while
// idle, then fetched, split into opcode/A/B and executed through a small ALU.
module alu_sequencer #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned OPW          = 3,
  parameter bit          HALT_ON_ZERO = 1'b1,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned IW          = OPW + 2 * WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             dir_i,
  input  logic             wrap_i,
  input  logic [AW-1:0]    start_addr_i,
  input  logic             prog_we_i,
  input  logic [AW-1:0]    prog_addr_i,
  input  logic [IW-1:0]    prog_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [AW-1:0]    pc_o,
  output logic [IW-1:0]    instr_o,
  output logic [OPW-1:0]   out_op_o,
  output logic [WIDTH-1:0] out_a_o,
  output logic [WIDTH-1:0] out_b_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             out_valid_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [WIDTH:0] WidthVal = (WIDTH + 1)'(WIDTH);

  logic [IW-1:0]    mem_q [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [IW-1:0]    s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;

  logic [IW-1:0]    instr_q, instr_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;

  logic [OPW-1:0]   op_f;
  logic [WIDTH-1:0] a_f, b_f;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH:0]   sum;
  logic             halt_hit;
  logic             at_end;
  logic             exec_en;

  assign op_f = s1_q[IW-1:2*WIDTH];
  assign a_f  = s1_q[2*WIDTH-1:WIDTH];
  assign b_f  = s1_q[WIDTH-1:0];
  assign sum  = {1'b0, a_f} + {1'b0, b_f};

  // A zero word waiting in stage 1 ends the run instead of executing.
  assign halt_hit = HALT_ON_ZERO && s1_valid_q && (s1_q == '0);
  assign at_end   = dir_i ? (pc_q == AW'(DEPTH - 1)) : (pc_q == '0);

  // ALU on the stage-1 word; results truncated to WIDTH.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_f)
      OPW'(0): begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OPW'(1): begin
        alu_res   = a_f - b_f;
        alu_carry = (a_f >= b_f);
      end
      OPW'(2): alu_res = ({1'b0, b_f} >= WidthVal) ? '0 : (a_f << b_f);
      OPW'(3): alu_res = ({1'b0, b_f} >= WidthVal) ? '0 : (a_f >> b_f);
      OPW'(4): alu_res = a_f & b_f;
      OPW'(5): alu_res = a_f | b_f;
      OPW'(6): alu_res = a_f ^ b_f;
      OPW'(7): alu_res = ~a_f;
      default: alu_res = '0;
    endcase
  end

  // Sequencer FSM, fetch stage and execute-stage next-state logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    instr_d     = instr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    exec_en     = 1'b0;

    case (state_q)
      StIdle: begin
        s1_valid_d = 1'b0;
        if (start_i && !stop_i) begin
          pc_d    = start_addr_i;
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop_i) begin
          state_d    = StIdle;
          s1_valid_d = 1'b0;
        end else if (halt_hit) begin
          state_d    = StIdle;
          s1_valid_d = 1'b0;
          done_d     = 1'b1;
        end else begin
          s1_d       = mem_q[pc_q];
          s1_valid_d = 1'b1;
          exec_en    = s1_valid_q;
          if (at_end && !wrap_i) begin
            state_d = StDrain;
          end else begin
            pc_d = dir_i ? (pc_q + AW'(1)) : (pc_q - AW'(1));
          end
        end
      end
      StDrain: begin
        state_d    = StIdle;
        s1_valid_d = 1'b0;
        if (!stop_i) begin
          done_d  = 1'b1;
          exec_en = s1_valid_q && !halt_hit;
        end
      end
      default: begin
        state_d    = StIdle;
        s1_valid_d = 1'b0;
      end
    endcase

    if (exec_en) begin
      instr_d     = s1_q;
      op_d        = op_f;
      a_d         = a_f;
      b_d         = b_f;
      result_d    = alu_res;
      carry_d     = alu_carry;
      zero_d      = (alu_res == '0);
      out_valid_d = 1'b1;
    end
  end

  // Pipeline and control state, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      instr_q     <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      instr_q     <= instr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // Program memory: writable only while idle, never reset.
  always_ff @(posedge clk_i) begin
    if (prog_we_i && (state_q == StIdle)) begin
      mem_q[prog_addr_i] <= prog_data_i;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign out_op_o    = op_q;
  assign out_a_o     = a_q;
  assign out_b_o     = b_q;
  assign result_o    = result_q;
  assign carry_o     = carry_q;
  assign zero_o      = zero_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Parametrised successor to the counter/ROM/splitter/ALU datapath.
- A writable instruction memory is walked by a program counter under FSM control. The counter runs up or down, with optional wrap and halt-on-zero-word.
- Each instruction is fetched, split and executed through a 2-stage registered pipeline. Each executed instruction is presented with the result, carry and zero flags.
- Sits between the test/program loader and the display/result logic.

Parameters:
- WIDTH, 8, operand/result width in bits.
- DEPTH, 64, instruction memory depth (power of 2). AW = clog2(DEPTH).
- OPW, 3, opcode width. Instruction width IW = OPW + 2*WIDTH (19 at defaults).
- HALT_ON_ZERO, 1, if 1, a fetched all-zero word ends the run.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low. 0 forces reset state immediately.
- start  in  1  begin a run at start_addr. Honoured only in IDLE.
- stop  in  1  abort a run. Honoured in RUN/DRAIN.
- dir  in  1  1 = pc increments, 0 = pc decrements. Sampled each fetch.
- wrap  in  1  1 = pc wraps at memory ends, 0 = run ends at memory end.
- start_addr  in  AW  first fetch address.
- prog_we  in  1  memory write enable. Honoured only in IDLE.
- prog_addr  in  AW  write address.
- prog_data  in  IW  write data.
- busy  out  1  1 in RUN or DRAIN.
- done  out  1  one-cycle pulse on natural completion.
- pc  out  AW  current program counter.
- instr  out  IW  instruction of the current output.
- out_op  out  OPW  opcode field.
- out_a  out  WIDTH  operand A.
- out_b  out  WIDTH  operand B.
- result  out  WIDTH  ALU result.
- carry  out  1  carry flag.
- zero  out  1  result == 0.
- out_valid  out  1  outputs hold a newly executed instruction this cycle.

Behaviour:
- Reset (reset=0):
  - State IDLE; pc=0; stage1 valid=0.
  - All outputs 0.
  - Memory array is not reset.
- Field split: op = instr[IW-1:2*WIDTH], A = instr[2*WIDTH-1:WIDTH], B = instr[WIDTH-1:0]. Fields are non-overlapping.
- Memory: synchronous write in IDLE; synchronous read into stage1 register. prog_we outside IDLE is ignored.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 (and stop=0): pc <= start_addr; go to RUN.
  - start with stop in the same cycle: stop wins, remain IDLE.
- RUN, each edge:
  - stage1 <= mem[pc], s1_valid <= 1.
  - pc <= pc+1 if dir=1, pc-1 if dir=0, modulo DEPTH.
  - If wrap=0 and the fetch is at DEPTH-1 with dir=1, or at 0 with dir=0: pc holds, go to DRAIN.
- Execute stage, on each edge with s1_valid=1:
  - Register instr, op, A, B, result, carry and zero; out_valid=1.
  - If s1_valid=0, out_valid=0 and the other outputs hold.
- DRAIN: the last stage1 word executes; done=1 on that same edge; go to IDLE.
- Halt on zero (HALT_ON_ZERO=1 and the stage1 word == 0):
  - The zero word is not executed; out_valid=0.
  - The fetch made on that same edge is discarded; s1_valid <= 0.
  - done=1; go to IDLE. This applies in both RUN and DRAIN.
- Stop (stop=1 in RUN/DRAIN):
  - Next state IDLE; s1_valid cleared.
  - No out_valid from that edge on; done stays 0; pc holds.
- Latency:
  - Start edge E0 → first fetch at E1 → first out_valid after E2.
  - Throughput is 1 instruction per cycle.
- ALU ops, results truncated to WIDTH:
  - 0 add: carry = carry-out.
  - 1 sub A-B: carry = 1 if A>=B (no borrow).
  - 2 shift left A<<B, and 3 shift right A>>B: result 0 if B>=WIDTH.
  - 4 and, 5 or, 6 xor, 7 not A.
  - carry = 0 for ops 2-7.
  - OPW>3: opcodes above 7 give result 0.
- Async reset mid-run: immediate return to reset values. No done pulse.

Test Plan:
- Load addr0..3 = 19'h01713, 19'h1034C, 19'h21F05, 0; start_addr=0, dir=1 → 3 out_valid on consecutive cycles, first out_valid 2 cycles after the start edge:
  - result=0x2A, carry=0.
  - result=0xB7, carry=0.
  - result=0xE0.
  - Then done pulse, busy=0, no out_valid for the zero word.
- Load 19'h0FF01 at addr 5 and 0 at addr 6; start at 5 → result=0x00, carry=1, zero=1; done next cycle.
- Down-count boundary: fill addr 2..0 non-zero; start_addr=2, dir=0, wrap=0 → executes 2,1,0 then done; pc=0.
- Wrap: addr 63 and 0 non-zero, addr 1 = 0; start_addr=63, dir=1, wrap=1 → executes 63 then 0, halts at 1; done=1.
- Stop one cycle after the first out_valid during a long run → no further out_valid, done=0, busy=0 next cycle. prog_we during RUN leaves memory unchanged (verify by readback run).
- Assert reset=0 mid-run, asynchronously between edges → all outputs 0 immediately; start and stop together in IDLE → stays IDLE.
